// File: rtl/cache_types.sv
// Cache line type plus writeback-buffer FSM states and sizing constants.
package cache_types;

    typedef logic [127:0] cache_line;

    localparam int unsigned WB_MAX_DEPTH = 4;
    localparam int unsigned WB_PTR_W     = $clog2(WB_MAX_DEPTH);
    localparam int unsigned WB_CNT_W     = $clog2(WB_MAX_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        RESP      = 2'd3
    } wb_state_t;

endpackage

// File: rtl/lc3b_types.sv
// LC-3b processor word type shared across the memory hierarchy.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

endpackage

// File: rtl/writeback_buffer_fifo.sv
// Entry storage, FIFO pointers and address match for the writeback buffer.
// WB_READ_FORWARD_EN adds the matched-entry data output used for read forwarding.
module writeback_buffer_fifo
    import cache_types::*;
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  lc3b_word  i_addr,
    input  cache_line i_data,
    input  logic      i_write,
    input  logic      i_pop,
    output lc3b_word  o_head_addr_c,
    output cache_line o_head_data_c,
    output logic      o_hit_c,
`ifdef WB_READ_FORWARD_EN
    output cache_line o_hit_data_c,
`endif
    output logic      o_full_c,
    output logic      o_empty_c
);

    logic [WB_PTR_W-1:0]     r_head;
    logic [WB_PTR_W-1:0]     r_tail;
    logic [WB_CNT_W-1:0]     r_count;
    logic [WB_MAX_DEPTH-1:0] r_valid;
    lc3b_word                r_addr [WB_MAX_DEPTH];
    cache_line               r_data [WB_MAX_DEPTH];

    logic                    w_hit;
    logic [WB_PTR_W-1:0]     w_hit_idx;
    logic                    w_push;
    logic                    w_pop;

    function automatic logic [WB_PTR_W-1:0] ptr_inc(input logic [WB_PTR_W-1:0] p);
        return (p == WB_PTR_W'(DEPTH - 1)) ? '0 : p + WB_PTR_W'(1);
    endfunction

    // Coalescing keeps valid addresses unique, so at most one entry matches.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < int'(WB_MAX_DEPTH); i++) begin
            if (r_valid[i] && (r_addr[i] == i_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = WB_PTR_W'(i);
            end
        end
    end

    assign o_full_c      = (r_count == WB_CNT_W'(DEPTH));
    assign o_empty_c     = (r_count == '0);
    assign o_hit_c       = w_hit;
    assign o_head_addr_c = r_addr[r_head];
    assign o_head_data_c = r_data[r_head];
`ifdef WB_READ_FORWARD_EN
    assign o_hit_data_c  = r_data[w_hit_idx];
`endif

    assign w_push = i_write && !w_hit && !o_full_c;
    assign w_pop  = i_pop && !o_empty_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + WB_CNT_W'(1);
                2'b01:   r_count <= r_count - WB_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_data;
        end else if (i_write && w_hit) begin
            r_data[w_hit_idx] <= i_data;
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer between victim cache and physical memory: FSM and muxing.
// Define WB_READ_FORWARD_EN to answer reads that hit a buffered line directly.
module writeback_buffer
    import cache_types::*;
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  lc3b_word  mem_address,
    input  cache_line mem_wdata,
    input  logic      mem_read,
    input  logic      mem_write,
    output cache_line mem_rdata,
    output logic      mem_resp,
    input  cache_line pmem_rdata,
    input  logic      pmem_resp,
    output lc3b_word  pmem_address,
    output cache_line pmem_wdata,
    output logic      pmem_read,
    output logic      pmem_write
);

    wb_state_t r_state;
    wb_state_t w_state_nxt;
    cache_line r_mem_rdata;
    cache_line w_mem_rdata_nxt;
    logic      r_mem_resp;
    logic      w_mem_resp_nxt;
    lc3b_word  r_pmem_address;
    lc3b_word  w_pmem_address_nxt;
    cache_line r_pmem_wdata;
    cache_line w_pmem_wdata_nxt;
    logic      r_pmem_read;
    logic      w_pmem_read_nxt;
    logic      r_pmem_write;
    logic      w_pmem_write_nxt;

    logic      w_fifo_write;
    logic      w_fifo_pop;
    lc3b_word  w_head_addr;
    cache_line w_head_data;
    logic      w_hit;
    logic      w_full;
    logic      w_empty;
`ifdef WB_READ_FORWARD_EN
    cache_line w_hit_data;
`endif

    writeback_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_addr        (mem_address),
        .i_data        (mem_wdata),
        .i_write       (w_fifo_write),
        .i_pop         (w_fifo_pop),
        .o_head_addr_c (w_head_addr),
        .o_head_data_c (w_head_data),
        .o_hit_c       (w_hit),
`ifdef WB_READ_FORWARD_EN
        .o_hit_data_c  (w_hit_data),
`endif
        .o_full_c      (w_full),
        .o_empty_c     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_mem_rdata    <= '0;
            r_mem_resp     <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mem_rdata    <= w_mem_rdata_nxt;
            r_mem_resp     <= w_mem_resp_nxt;
            r_pmem_address <= w_pmem_address_nxt;
            r_pmem_wdata   <= w_pmem_wdata_nxt;
            r_pmem_read    <= w_pmem_read_nxt;
            r_pmem_write   <= w_pmem_write_nxt;
        end
    end

    // Reads win over drains; a read that hits the buffer without forwarding
    // drains the head repeatedly until the hit is gone, then goes to memory.
    always_comb begin
        w_state_nxt        = r_state;
        w_mem_rdata_nxt    = r_mem_rdata;
        w_mem_resp_nxt     = 1'b0;
        w_pmem_address_nxt = r_pmem_address;
        w_pmem_wdata_nxt   = r_pmem_wdata;
        w_pmem_read_nxt    = r_pmem_read;
        w_pmem_write_nxt   = r_pmem_write;
        w_fifo_write       = 1'b0;
        w_fifo_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                if (mem_read) begin
`ifdef WB_READ_FORWARD_EN
                    if (w_hit) begin
                        w_mem_rdata_nxt = w_hit_data;
                        w_mem_resp_nxt  = 1'b1;
                        w_state_nxt     = RESP;
                    end else begin
                        w_pmem_read_nxt    = 1'b1;
                        w_pmem_address_nxt = mem_address;
                        w_state_nxt        = MEM_READ;
                    end
`else
                    if (w_hit) begin
                        w_pmem_write_nxt   = 1'b1;
                        w_pmem_address_nxt = w_head_addr;
                        w_pmem_wdata_nxt   = w_head_data;
                        w_state_nxt        = MEM_WRITE;
                    end else begin
                        w_pmem_read_nxt    = 1'b1;
                        w_pmem_address_nxt = mem_address;
                        w_state_nxt        = MEM_READ;
                    end
`endif
                end else if (mem_write && (w_hit || !w_full)) begin
                    w_fifo_write   = 1'b1;
                    w_mem_resp_nxt = 1'b1;
                    w_state_nxt    = RESP;
                end else if (!w_empty) begin
                    w_pmem_write_nxt   = 1'b1;
                    w_pmem_address_nxt = w_head_addr;
                    w_pmem_wdata_nxt   = w_head_data;
                    w_state_nxt        = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (pmem_resp) begin
                    w_pmem_read_nxt = 1'b0;
                    w_mem_rdata_nxt = pmem_rdata;
                    w_mem_resp_nxt  = 1'b1;
                    w_state_nxt     = RESP;
                end
            end
            MEM_WRITE: begin
                if (pmem_resp) begin
                    w_pmem_write_nxt = 1'b0;
                    w_fifo_pop       = 1'b1;
                    w_state_nxt      = IDLE;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_rdata    = r_mem_rdata;
    assign mem_resp     = r_mem_resp;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;

endmodule

// File: tb/tb_writeback_buffer.sv
// Testbench for writeback_buffer: directed scenarios plus random traffic
// checked against a flat memory reference; honours WB_READ_FORWARD_EN.
module tb_writeback_buffer;

    logic         clk;
    logic         rst_n;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int overlap  = 0;
    int lat_force = 0;
    int pmem_resp_cyc = 0;

    logic [127:0] ref_mem  [logic [15:0]];
    logic [127:0] pmem_mem [logic [15:0]];
    bit           log_wr   [$];
    logic [15:0]  log_addr [$];
    logic [127:0] log_data [$];

    writeback_buffer #(
        .DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pmem_read && pmem_write) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] def_line(input logic [15:0] a);
        return {8{a}};
    endfunction

    function automatic logic [127:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_line(a);
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Physical memory: random 1-10 cycle latency, one-cycle resp, aborts on reset.
    initial begin : pmem_model
        int           lat;
        int           k;
        bit           abort;
        bit           is_wr;
        logic [15:0]  a;
        logic [127:0] d;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (pmem_read || pmem_write)) begin
                lat   = (lat_force != 0) ? lat_force : int'($urandom_range(10, 1));
                is_wr = pmem_write;
                a     = pmem_address;
                d     = pmem_wdata;
                abort = 1'b0;
                k     = 1;
                while (k < lat && !abort) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                    k++;
                end
                if (!abort && rst_n) begin
                    if (is_wr) pmem_mem[a] = d;
                    else pmem_rdata = pmem_mem.exists(a) ? pmem_mem[a] : def_line(a);
                    log_wr.push_back(is_wr);
                    log_addr.push_back(a);
                    log_data.push_back(d);
                    pmem_resp     = 1'b1;
                    pmem_resp_cyc = cyc;
                    @(negedge clk);
                    pmem_resp = 1'b0;
                end
            end
        end
    end

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // One upstream request, held until mem_resp (bounded).
    task automatic do_op(input bit wr, input logic [15:0] a, input logic [127:0] d,
                         output logic [127:0] rd, output int resp_c);
        int n;
        mem_address = a;
        mem_wdata   = d;
        mem_write   = wr;
        mem_read    = !wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 500);
        if (!mem_resp) check("op_timeout", 128'(n), 128'(0));
        rd        = mem_rdata;
        resp_c    = cyc;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (wr) ref_mem[a] = d;
    endtask

    // Waits until the pmem port has been quiet long enough that the buffer is empty.
    task automatic wait_drain();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 25 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pmem_read || pmem_write || pmem_resp) quiet = 0;
            else quiet++;
        end
        if (quiet < 25) check("drain_timeout", 128'(quiet), 128'(25));
    endtask

    initial begin : main
        logic [127:0] rd;
        logic [127:0] exp;
        logic [127:0] da;
        logic [127:0] db;
        logic [15:0]  a;
        int           rc;
        int           nreads;
        int           n;

        rst_n       = 1'b1;
        mem_address = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_mem_resp",   128'(mem_resp),   128'(0));
        check("rst_pmem_read",  128'(pmem_read),  128'(0));
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_mem_rdata",  mem_rdata,        128'(0));
        check("rst_pmem_addr",  128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata,       128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back writes to one line coalesce into a single drain.
        clear_log();
        da = rnd_line();
        db = rnd_line();
        do_op(1'b1, 16'h1000, da, rd, rc);
        do_op(1'b1, 16'h1000, db, rd, rc);
        wait_drain();
        check("coal_count", 128'(log_addr.size()), 128'(1));
        if (log_addr.size() > 0) begin
            check("coal_addr", 128'(log_addr[0]), 128'(16'h1000));
            check("coal_data", log_data[0], db);
            check("coal_is_wr", 128'(log_wr[0]), 128'(1));
        end

        // A pending read goes to memory before the buffered write drains.
        clear_log();
        do_op(1'b1, 16'h1230, da, rd, rc);
        do_op(1'b0, 16'h4560, '0, rd, rc);
        check("rd_data", rd, ref_read(16'h4560));
        check("rd_resp_lat", 128'(rc), 128'(pmem_resp_cyc + 1));
        wait_drain();
        check("prio_count", 128'(log_addr.size()), 128'(2));
        if (log_addr.size() > 1) begin
            check("prio_first_rd", 128'(log_wr[0]), 128'(0));
            check("prio_first_addr", 128'(log_addr[0]), 128'(16'h4560));
            check("prio_second_wr", 128'(log_wr[1]), 128'(1));
            check("prio_second_addr", 128'(log_addr[1]), 128'(16'h1230));
        end

        // Full buffer stalls a new line until the head has drained.
        clear_log();
        do_op(1'b1, 16'h1000, rnd_line(), rd, rc);
        do_op(1'b1, 16'h2000, rnd_line(), rd, rc);
        do_op(1'b1, 16'h3000, rnd_line(), rd, rc);
        check("full_drained_before_resp", 128'(log_addr.size()), 128'(1));
        if (log_addr.size() > 0) check("full_head_addr", 128'(log_addr[0]), 128'(16'h1000));
        wait_drain();
        check("full_total", 128'(log_addr.size()), 128'(3));
        if (log_addr.size() > 2) begin
            check("full_order_1", 128'(log_addr[1]), 128'(16'h2000));
            check("full_order_2", 128'(log_addr[2]), 128'(16'h3000));
        end

        // Read of a line still in the buffer.
        clear_log();
        da = rnd_line();
        do_op(1'b1, 16'h2000, da, rd, rc);
        do_op(1'b0, 16'h2000, '0, rd, rc);
        check("hit_rd_data", rd, da);
        wait_drain();
        nreads = 0;
        foreach (log_wr[i]) if (!log_wr[i]) nreads++;
`ifdef WB_READ_FORWARD_EN
        check("fwd_no_pmem_read", 128'(nreads), 128'(0));
        check("fwd_one_drain", 128'(log_addr.size()), 128'(1));
`else
        check("nofwd_reads", 128'(nreads), 128'(1));
        check("nofwd_count", 128'(log_addr.size()), 128'(2));
        if (log_addr.size() > 1) begin
            check("nofwd_first_wr", 128'(log_wr[0]), 128'(1));
            check("nofwd_first_addr", 128'(log_addr[0]), 128'(16'h2000));
            check("nofwd_then_rd_addr", 128'(log_addr[1]), 128'(16'h2000));
        end
`endif

        // Random traffic over a small set of lines to exercise hits and stalls.
        for (int i = 0; i < 1000; i++) begin
            a = 16'h8000 | (16'($urandom_range(7, 0)) << 4);
            if ($urandom_range(1, 0) == 1) begin
                do_op(1'b1, a, rnd_line(), rd, rc);
            end else begin
                exp = ref_read(a);
                do_op(1'b0, a, '0, rd, rc);
                check("rnd_rd", rd, exp);
            end
        end
        wait_drain();
        foreach (ref_mem[k]) begin
            check("final_mem", pmem_mem.exists(k) ? pmem_mem[k] : def_line(k), ref_mem[k]);
        end
        check("no_rw_overlap", 128'(overlap), 128'(0));

        // Reset during a drain drops the strobe at once and discards the line.
        lat_force = 10;
        do_op(1'b1, 16'h5000, rnd_line(), rd, rc);
        clear_log();
        n = 0;
        while (!(pmem_write && pmem_address == 16'h5000) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_drain_started", 128'(pmem_write), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_mid_pmem_addr", 128'(pmem_address), 128'(0));
        check("rst_mid_mem_resp", 128'(mem_resp), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lat_force = 0;
        repeat (40) @(negedge clk);
        check("rst_no_later_write", 128'(log_addr.size()), 128'(0));
        check("rst_line_discarded", 128'(pmem_mem.exists(16'h5000)), 128'(0));
        check("rst_end_pmem_write", 128'(pmem_write), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
